pwm_dac_ramp: RTL
=================

# pwm_dac_ramp

Multi-channel PWM volume DAC with glitch-free, period-synchronous level updates and linear ramping toward a programmed target. It replaces the single-channel free-running comparator on the audio output path. Register-facing logic writes per-channel targets. The block ramps each channel's duty cycle in fixed steps, one step per PWM period, so that volume changes and mute/unmute produce no audible clicks.

## Interface
- SYS_FREQ_HZ, mandatory: system clock frequency in Hz.
- PWM_FREQ, mandatory: PWM frequency in Hz.
- PWM_PERIOD, SYS_FREQ_HZ/PWM_FREQ: cycles per PWM period; must be ≥ 2.
- COUNT_WIDTH, $clog2(PWM_PERIOD): period counter width.
- DATA_WIDTH, 8: level width per channel.
- CHANNELS, 2: number of PWM outputs, 1..8.
- RAMP_STEP, 1: level change per PWM period; must be ≥ 1.

Ports (clock and reset first):
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-high.
- target  in  CHANNELS*DATA_WIDTH  packed targets; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- load  in  CHANNELS  per-channel strobe that captures the target slice into the shadow register.
- mute  in  1  level-sensitive; while high, every channel's effective target is 0.
- pwm_out  out  CHANNELS  PWM outputs, registered.
- period_start  out  1  one-cycle pulse in the first cycle of each period.
- busy  out  1  high while any channel level ≠ its effective target.

## Operation
- Counter runs 0..PWM_PERIOD-1 and then wraps to 0. The boundary is the cycle in which the counter = PWM_PERIOD-1.
- Shadow register per channel. A load bit high on a clock edge captures the slice. Multiple loads within one period: the last one wins.
- Effective target = mute ? 0 : shadow.
- Level update happens only at the boundary edge:
  - If level < effective target: level = min(level+RAMP_STEP, effective target).
  - If level > effective target: level = max(level-RAMP_STEP, effective target).
  - Otherwise level holds.
  - Arithmetic is carried out at DATA_WIDTH+1 bits, with no wrap past 0 or 2^DATA_WIDTH-1.
- pwm_out[i] = registered (counter < level[i]), zero-extended compare.
  - level = 0 gives constant low.
  - level ≥ PWM_PERIOD gives constant high.
- Because the level changes only at the boundary, every period has a single consistent duty cycle.
- A load or mute change coinciding with the boundary edge is not seen by that boundary's update. It is applied from the next boundary onward.
- Mute takes effect only through ramping. Deasserting mute mid-ramp reverses direction at the next boundary.
- busy = OR over channels of (level ≠ effective target), registered.
- Reset mid-operation immediately clears the counter, levels, shadows and all outputs.

## Timing
- Reset values: counter 0; level 0; shadow 0; pwm_out 0; period_start 0; busy 0.
- period_start is high in the cycle in which the counter = 0, asserted from the first cycle after reset release.
- pwm_out lags the counter by 1 cycle. Output high time per period = min(level, PWM_PERIOD) cycles.
- Ramp from a to b takes ceil(|b-a|/RAMP_STEP) periods.
- busy goes high 1 cycle after a load or mute change creates a mismatch. It falls 1 cycle after the boundary at which the final level is reached.

## Structure
- Shared package/include pwm_dac_pkg: ramp-direction encoding and parameter legality checks (PWM_PERIOD ≥ 2, CHANNELS range, RAMP_STEP ≥ 1).
- Top level: period counter, period_start, busy reduction.
- Sub-module pwm_dac_channel, instantiated CHANNELS times, with inputs counter, boundary, target slice, load bit and mute. It contains the shadow register, ramp logic, compare and output register.

## Test plan
All scenarios use SYS_FREQ_HZ=1000, PWM_FREQ=10 (PWM_PERIOD=100), DATA_WIDTH=8, CHANNELS=2, RAMP_STEP=10.
- Reset and idle: hold reset, then release → pwm_out=0 and busy=0 throughout; period_start pulses every 100 cycles.
- Ramp up: load ch0=35 → successive periods show high times 10, 20, 30, 35, 35; busy falls after the 4th boundary; ch1 stays 0.
- Saturation: load ch1=200 → high time climbs to 100 (constant high) by period 10; level settles at 200; busy clears after 20 boundaries.
- Mute/unmute: with ch0 at 50, assert mute → high times 40, 30, 20, 10, 0; deassert mute after the 20 period → 30, 40, 50.
- Boundary race: pulse load ch0=80 (from level 0) exactly on a boundary edge → no change at that boundary; the step to 10 occurs at the next one. Two loads in one period (20, then 60) → the ramp targets 60.
- Async reset mid-ramp: assert reset during the period with high time 30 → all outputs 0 within the same cycle; after release the ramp restarts from level 0 and needs a fresh load.

Source files
------------

// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg
// Shared definitions for the multi-channel PWM volume DAC.
//   ramp_dir_e    : which way a channel level moves at the next boundary
//   period_ok     : the PWM period must cover at least two clock cycles
//   channels_ok   : 1..MAX_CHANNELS outputs
//   step_ok       : a ramp step of zero would never converge
//   clamp_step    : limits the ramp step to the full-scale level so that the
//                   (DATA_WIDTH+1)-bit ramp arithmetic never sees a truncated step
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    RAMP_HOLD = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } ramp_dir_e;

  localparam int MIN_PWM_PERIOD = 2;
  localparam int MAX_CHANNELS   = 8;

  function automatic bit period_ok(input int period);
    return period >= MIN_PWM_PERIOD;
  endfunction

  function automatic bit channels_ok(input int channels);
    return (channels >= 1) && (channels <= MAX_CHANNELS);
  endfunction

  function automatic bit step_ok(input int step);
    return step >= 1;
  endfunction

  function automatic bit count_width_ok(input int count_width, input int period);
    return count_width >= $clog2(period);
  endfunction

  // A step larger than full scale behaves exactly like a full-scale step,
  // because every move is clamped to the effective target anyway.
  function automatic int clamp_step(input int step, input int data_width);
    int full_scale;
    full_scale = (2 ** data_width) - 1;
    return (step > full_scale) ? full_scale : step;
  endfunction

endpackage

// File: rtl/pwm_dac_channel.sv
// pwm_dac_channel
// One PWM channel: shadow target register, linear ramp toward the effective
// target (one step per PWM period), duty compare and registered output.
//   clk       : system clock
//   resetn    : asynchronous reset, active high
//   counter   : shared period counter from the top level
//   boundary  : high in the last cycle of each period (counter = PERIOD-1)
//   target    : this channel's target slice
//   load      : captures target into the shadow register
//   mute      : forces the effective target to zero (through the ramp)
//   pwm_out   : registered PWM output
//   mismatch  : level differs from the effective target (combinational)
module pwm_dac_channel
  import pwm_dac_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 7,
  parameter int RAMP_STEP   = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [COUNT_WIDTH-1:0] counter,
  input  logic                   boundary,
  input  logic [DATA_WIDTH-1:0]  target,
  input  logic                   load,
  input  logic                   mute,
  output logic                   pwm_out,
  output logic                   mismatch
);

  localparam int CMP_WIDTH = (COUNT_WIDTH > DATA_WIDTH) ? COUNT_WIDTH : DATA_WIDTH;
  localparam logic [DATA_WIDTH:0] STEP_EXT =
    (DATA_WIDTH+1)'(clamp_step(RAMP_STEP, DATA_WIDTH));

  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic                  mute_q, mute_d;
  logic                  pwm_q, pwm_d;

  logic [DATA_WIDTH-1:0] eff_target;
  logic [DATA_WIDTH:0]   level_ext;
  logic [DATA_WIDTH:0]   eff_ext;
  logic [DATA_WIDTH:0]   gap;
  ramp_dir_e             dir;
  logic [CMP_WIDTH-1:0]  cnt_cmp;
  logic [CMP_WIDTH-1:0]  lvl_cmp;

  // Mute is registered so that, like load, a change sampled on the boundary
  // edge only influences the following boundary.
  always_comb begin
    eff_target = mute_q ? '0 : shadow_q;
    level_ext  = {1'b0, level_q};
    eff_ext    = {1'b0, eff_target};
    dir        = RAMP_HOLD;
    gap        = '0;
    if (level_ext < eff_ext) begin
      dir = RAMP_UP;
      gap = eff_ext - level_ext;
    end else if (level_ext > eff_ext) begin
      dir = RAMP_DOWN;
      gap = level_ext - eff_ext;
    end
  end

  // When the remaining gap exceeds the step, level+step stays below the target
  // (and level-step stays above it), so the truncation back to DATA_WIDTH
  // cannot wrap.
  always_comb begin
    shadow_d = load ? target : shadow_q;
    mute_d   = mute;
    level_d  = level_q;
    if (boundary) begin
      case (dir)
        RAMP_UP:   level_d = (gap <= STEP_EXT) ? eff_target
                                               : DATA_WIDTH'(level_ext + STEP_EXT);
        RAMP_DOWN: level_d = (gap <= STEP_EXT) ? eff_target
                                               : DATA_WIDTH'(level_ext - STEP_EXT);
        default:   level_d = level_q;
      endcase
    end
    cnt_cmp = CMP_WIDTH'(counter);
    lvl_cmp = CMP_WIDTH'(level_q);
    pwm_d   = (cnt_cmp < lvl_cmp);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      shadow_q <= '0;
      level_q  <= '0;
      mute_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      level_q  <= level_d;
      mute_q   <= mute_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out  = pwm_q;
  assign mismatch = (dir != RAMP_HOLD);

endmodule

// File: rtl/pwm_dac_ramp.sv
// pwm_dac_ramp
// Multi-channel PWM volume DAC with period-synchronous ramped level updates.
// Holds the shared period counter, the period_start pulse and the busy
// reduction; each channel's ramp and compare live in pwm_dac_channel.
//   clk           : system clock
//   resetn        : asynchronous reset, active high
//   target        : packed per-channel targets, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   load          : per-channel shadow-register capture strobe
//   mute          : level-sensitive; ramps every channel toward zero while high
//   pwm_out       : registered PWM outputs
//   period_start  : high in the cycle the period counter is 0
//   busy          : registered OR of per-channel level/target mismatch
module pwm_dac_ramp
  import pwm_dac_pkg::*;
#(
  parameter int SYS_FREQ_HZ = 1000,
  parameter int PWM_FREQ    = 10,
  parameter int PWM_PERIOD  = SYS_FREQ_HZ / PWM_FREQ,
  parameter int COUNT_WIDTH = $clog2(PWM_PERIOD),
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 2,
  parameter int RAMP_STEP   = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [CHANNELS*DATA_WIDTH-1:0] target,
  input  logic [CHANNELS-1:0]            load,
  input  logic                           mute,
  output logic [CHANNELS-1:0]            pwm_out,
  output logic                           period_start,
  output logic                           busy
);

  if (!period_ok(PWM_PERIOD)) begin : g_bad_period
    $error("pwm_dac_ramp: PWM_PERIOD must be at least 2");
  end
  if (!channels_ok(CHANNELS)) begin : g_bad_channels
    $error("pwm_dac_ramp: CHANNELS must be in 1..8");
  end
  if (!step_ok(RAMP_STEP)) begin : g_bad_step
    $error("pwm_dac_ramp: RAMP_STEP must be at least 1");
  end
  if (!count_width_ok(COUNT_WIDTH, PWM_PERIOD)) begin : g_bad_count_width
    $error("pwm_dac_ramp: COUNT_WIDTH too narrow for PWM_PERIOD");
  end

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(PWM_PERIOD - 1);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   boundary;
  logic [CHANNELS-1:0]    mismatch;

  always_comb begin
    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + COUNT_WIDTH'(1);
    busy_d   = |mismatch;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // The counter already sits at 0 during reset; gating with reset keeps the
  // pulse low while held and lets it fire in the first cycle after release.
  assign period_start = (cnt_q == '0) & ~resetn;
  assign busy         = busy_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_dac_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH),
      .RAMP_STEP  (RAMP_STEP)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .counter (cnt_q),
      .boundary(boundary),
      .target  (target[i*DATA_WIDTH +: DATA_WIDTH]),
      .load    (load[i]),
      .mute    (mute),
      .pwm_out (pwm_out[i]),
      .mismatch(mismatch[i])
    );
  end

endmodule
